// File: rtl/instr_encoder.sv
// instr_encoder: streaming MIPS assembler back end.
// Takes one mnemonic token per accept and produces registered machine words
// tagged with their instruction-memory byte address. LI may expand to two
// words (lui/ori). Rejected tokens are consumed silently apart from an err pulse.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_mnem,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_instr,
  output logic        err,
  output logic        err_sticky
);

  localparam logic [3:0] M_NOP = 4'd0;
  localparam logic [3:0] M_ADD = 4'd1;
  localparam logic [3:0] M_SUB = 4'd2;
  localparam logic [3:0] M_JR  = 4'd3;
  localparam logic [3:0] M_ORI = 4'd4;
  localparam logic [3:0] M_LW  = 4'd5;
  localparam logic [3:0] M_SW  = 4'd6;
  localparam logic [3:0] M_BEQ = 4'd7;
  localparam logic [3:0] M_LUI = 4'd8;
  localparam logic [3:0] M_JAL = 4'd9;
  localparam logic [3:0] M_LI  = 4'd10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;

  typedef enum logic [1:0] {IDLE, EMIT, EMIT2} state_t;

  // Result of encoding the token currently on the input side.
  typedef struct packed {
    logic [31:0] word;   // first (or only) machine word
    logic        bad;    // token must be rejected
    logic        split;  // LI needs a second word
    logic [31:0] lo;     // second LI word (ori rt, rt, imm[15:0])
  } enc_t;

  state_t      state;
  logic [31:0] cnt;       // address of the word on out_* (or the next one)
  logic        li_pend;   // second LI word still to be presented
  logic [31:0] li_lo;

  logic        hs, acc;
  logic [31:0] waddr, pc4;
  logic signed [31:0] boff;
  enc_t        enc;

  assign hs  = out_valid && out_ready;
  assign acc = in_valid && in_ready;

  // Accepting in EMIT only happens alongside a handshake, so the new word
  // lands one slot past the current one.
  assign waddr = hs ? cnt + 32'd4 : cnt;
  assign pc4   = waddr + 32'd4;
  assign boff  = $signed(in_imm - pc4) >>> 2;

  assign in_ready = (state == IDLE) || ((state == EMIT) && out_ready && !li_pend);
  assign out_addr = cnt;

  // Encode the incoming token and classify it as legal or rejected.
  always_comb begin
    enc = '0;
    case (in_mnem)
      M_NOP: enc.word = 32'd0;
      M_ADD: enc.word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'd0, FN_ADD};
      M_SUB: enc.word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'd0, FN_SUB};
      M_JR:  enc.word = {OP_RTYPE, in_rs, 15'd0, FN_JR};
      M_ORI: enc.word = {OP_ORI, in_rs, in_rt, in_imm[15:0]};
      M_LW:  enc.word = {OP_LW,  in_rs, in_rt, in_imm[15:0]};
      M_SW:  enc.word = {OP_SW,  in_rs, in_rt, in_imm[15:0]};
      M_LUI: enc.word = {OP_LUI, 5'd0,  in_rt, in_imm[15:0]};
      M_BEQ: begin
        enc.word = {OP_BEQ, in_rs, in_rt, boff[15:0]};
        // offset must be a sign-extended 16-bit value: bits 31..15 all equal
        enc.bad  = (in_imm[1:0] != 2'b00) ||
                   !((boff[31:15] == 17'h00000) || (boff[31:15] == 17'h1FFFF));
      end
      M_JAL: begin
        enc.word = {OP_JAL, in_imm[27:2]};
        enc.bad  = (in_imm[1:0] != 2'b00) || (in_imm[31:28] != pc4[31:28]);
      end
      M_LI: begin
        if (in_imm[31:16] != 16'd0) begin
          enc.word  = {OP_LUI, 5'd0, in_rt, in_imm[31:16]};
          enc.split = 1'b1;
          enc.lo    = {OP_ORI, in_rt, in_rt, in_imm[15:0]};
        end else begin
          enc.word  = {OP_ORI, 5'd0, in_rt, in_imm[15:0]};
        end
      end
      default: enc.bad = 1'b1;
    endcase
  end

  // Output FSM: holds the presented word, sequences LI halves, tracks address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= BASE_ADDR;
      out_valid  <= 1'b0;
      out_instr  <= 32'd0;
      li_pend    <= 1'b0;
      li_lo      <= 32'd0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      err <= acc && enc.bad;
      if (acc && enc.bad) err_sticky <= 1'b1;
      if (hs) cnt <= cnt + 32'd4;

      case (state)
        IDLE: begin
          if (acc && !enc.bad) begin
            out_valid <= 1'b1;
            out_instr <= enc.word;
            li_pend   <= enc.split;
            li_lo     <= enc.lo;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (hs) begin
            if (li_pend) begin
              out_instr <= li_lo;
              li_pend   <= 1'b0;
              state     <= EMIT2;
            end else if (acc && !enc.bad) begin
              out_instr <= enc.word;
              li_pend   <= enc.split;
              li_lo     <= enc.lo;
            end else begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        EMIT2: begin
          if (hs) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          li_pend   <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded MIPS words checked per scenario.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, out_ready;
  logic [3:0]  in_mnem;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [31:0] in_imm;
  logic        in_ready, out_valid, err, err_sticky;
  logic [31:0] out_addr, out_instr;
  logic        in_ready2, out_valid2, err2, err_sticky2;
  logic [31:0] out_addr2, out_instr2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_instr(out_instr), .err(err), .err_sticky(err_sticky)
  );

  // Second instance parked near the top of the address space for the wrap case.
  instr_encoder #(.BASE_ADDR(32'hFFFF_FFFC)) dut_hi (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(out_valid2), .out_ready(out_ready), .out_addr(out_addr2),
    .out_instr(out_instr2), .err(err2), .err_sticky(err_sticky2)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic tok(input logic [3:0] m, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic [31:0] imm);
    in_valid = 1'b1; in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; reset = 1'b0;
    step(); step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    out_ready = 1'b0; in_mnem = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
    do_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if (out_instr !== 32'd0) begin failures++; $display("FAIL reset_instr got=%h exp=0", out_instr); end
    checks++; if (out_addr !== 32'h3000) begin failures++; $display("FAIL reset_addr got=%h exp=00003000", out_addr); end
    checks++; if (err !== 1'b0 || err_sticky !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b%0b exp=00", err, err_sticky); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_add();
    tok(4'd1, 5'd9, 5'd10, 5'd8, 32'd0);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%0b exp=1", out_valid); end
    checks++; if (out_addr !== 32'h3000) begin failures++; $display("FAIL add_addr got=%h exp=00003000", out_addr); end
    checks++; if (out_instr !== 32'h012A4020) begin failures++; $display("FAIL add_instr got=%h exp=012a4020", out_instr); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || out_addr !== 32'h3004) begin failures++; $display("FAIL add_drain got=%0b/%h exp=0/00003004", out_valid, out_addr); end
  endtask

  task automatic test_li();
    do_reset();
    out_ready = 1'b0;
    tok(4'd10, 5'd0, 5'd8, 5'd0, 32'h1234_5678);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h3C081234 || out_addr !== 32'h3000) begin failures++; $display("FAIL li_hi got=%0b/%h@%h exp=1/3c081234@00003000", out_valid, out_instr, out_addr); end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL li_hi_ready got=%0b exp=0", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h35085678 || out_addr !== 32'h3004) begin failures++; $display("FAIL li_lo got=%0b/%h@%h exp=1/35085678@00003004", out_valid, out_instr, out_addr); end
    step();
    checks++; if (out_valid !== 1'b0 || out_addr !== 32'h3008 || in_ready !== 1'b1) begin failures++; $display("FAIL li_done got=%0b/%h/%0b exp=0/00003008/1", out_valid, out_addr, in_ready); end
  endtask

  task automatic test_back_to_back();
    // continues at 0x3008 after the LI pair
    tok(4'd7, 5'd8, 5'd9, 5'd0, 32'h3000);
    step();
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h1109FFFD || out_addr !== 32'h3008) begin failures++; $display("FAIL beq got=%0b/%h@%h exp=1/1109fffd@00003008", out_valid, out_instr, out_addr); end
    tok(4'd9, 5'd0, 5'd0, 5'd0, 32'h3000);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%0b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h0C000C00 || out_addr !== 32'h300C) begin failures++; $display("FAIL jal got=%0b/%h@%h exp=1/0c000c00@0000300c", out_valid, out_instr, out_addr); end
    step();
    checks++; if (out_valid !== 1'b0 || out_addr !== 32'h3010) begin failures++; $display("FAIL jal_drain got=%0b/%h exp=0/00003010", out_valid, out_addr); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    tok(4'd4, 5'd1, 5'd2, 5'd0, 32'h0000_00FF);
    step();
    tok(4'd2, 5'd4, 5'd5, 5'd3, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b1 || out_instr !== 32'h342200FF || out_addr !== 32'h3010 || in_ready !== 1'b0) begin failures++; $display("FAIL stall_hold[%0d] got=%0b/%h@%h rdy=%0b exp=1/342200ff@00003010 rdy=0", i, out_valid, out_instr, out_addr, in_ready); end
    end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_release_ready got=%0b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h00851822 || out_addr !== 32'h3014) begin failures++; $display("FAIL sub_nobubble got=%0b/%h@%h exp=1/00851822@00003014", out_valid, out_instr, out_addr); end
    step();
    checks++; if (out_valid !== 1'b0 || out_addr !== 32'h3018) begin failures++; $display("FAIL sub_drain got=%0b/%h exp=0/00003018", out_valid, out_addr); end
  endtask

  task automatic test_errors();
    tok(4'd15, 5'd0, 5'd0, 5'd0, 32'd0);
    step();
    checks++; if (err !== 1'b1 || err_sticky !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL err_illegal got=%0b%0b/%0b exp=11/0", err, err_sticky, out_valid); end
    tok(4'd7, 5'd8, 5'd9, 5'd0, 32'h3002);
    step();
    checks++; if (err !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL err_beq_align got=%0b/%0b exp=1/0", err, out_valid); end
    tok(4'd9, 5'd0, 5'd0, 5'd0, 32'h1000_0000);
    step();
    checks++; if (err !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL err_jal_region got=%0b/%0b exp=1/0", err, out_valid); end
    tok(4'd7, 5'd1, 5'd2, 5'd0, 32'h0004_0000);
    step();
    checks++; if (err !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL err_beq_range got=%0b/%0b exp=1/0", err, out_valid); end
    in_valid = 1'b0;
    step();
    checks++; if (err !== 1'b0 || err_sticky !== 1'b1 || out_addr !== 32'h3018) begin failures++; $display("FAIL err_after got=%0b%0b/%h exp=01/00003018", err, err_sticky, out_addr); end
    tok(4'd5, 5'd29, 5'd8, 5'd0, 32'h0000_0004);
    step();
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h8FA80004 || out_addr !== 32'h3018) begin failures++; $display("FAIL lw_after_err got=%0b/%h@%h exp=1/8fa80004@00003018", out_valid, out_instr, out_addr); end
    tok(4'd10, 5'd0, 5'd3, 5'd0, 32'h0000_ABCD);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h3403ABCD || out_addr !== 32'h301C) begin failures++; $display("FAIL li_short got=%0b/%h@%h exp=1/3403abcd@0000301c", out_valid, out_instr, out_addr); end
    step();
    checks++; if (out_valid !== 1'b0 || out_addr !== 32'h3020) begin failures++; $display("FAIL li_short_single got=%0b/%h exp=0/00003020", out_valid, out_addr); end
  endtask

  task automatic test_reset_mid_li();
    do_reset();
    out_ready = 1'b1;
    tok(4'd10, 5'd0, 5'd8, 5'd0, 32'h1234_5678);
    step();
    in_valid = 1'b0;
    checks++; if (out_instr !== 32'h3C081234) begin failures++; $display("FAIL mid_li_hi got=%h exp=3c081234", out_instr); end
    reset = 1'b0;
    step();
    reset = 1'b1;
    checks++; if (out_valid !== 1'b0 || out_addr !== 32'h3000 || err_sticky !== 1'b0) begin failures++; $display("FAIL mid_li_reset got=%0b/%h/%0b exp=0/00003000/0", out_valid, out_addr, err_sticky); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_li_no_ori[%0d] got=%0b exp=0", i, out_valid); end
    end
    tok(4'd1, 5'd9, 5'd10, 5'd8, 32'd0);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h012A4020 || out_addr !== 32'h3000) begin failures++; $display("FAIL mid_li_add got=%0b/%h@%h exp=1/012a4020@00003000", out_valid, out_instr, out_addr); end
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    #1;
    checks++; if (out_addr2 !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_base got=%h exp=fffffffc", out_addr2); end
    tok(4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid2 !== 1'b1 || out_instr2 !== 32'd0 || out_addr2 !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_word got=%0b/%h@%h exp=1/00000000@fffffffc", out_valid2, out_instr2, out_addr2); end
    step();
    checks++; if (out_addr2 !== 32'd0 || err2 !== 1'b0 || err_sticky2 !== 1'b0) begin failures++; $display("FAIL wrap_zero got=%h/%0b%0b exp=00000000/00", out_addr2, err2, err_sticky2); end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    test_reset();
    test_add();
    test_li();
    test_back_to_back();
    test_stall();
    test_errors();
    test_reset_mid_li();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
